syn_pipe_stage: RTL

SYN_PIPE_STAGE -- requirements
Module: syn_pipe_stage

---
 rtl/syn_pipe_stage.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/syn_pipe_stage.sv
// syn_pipe_stage: valid/ready pipeline register with an optional skid entry.
// Define SYN_PIPE_SKID_EN to add the skid entry and register in_ready (no out_ready -> in_ready path).
module syn_pipe_stage #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_DATA = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             out_valid_q, out_valid_d;
    logic [1:0]       occ_q, occ_d;
`ifdef SYN_PIPE_SKID_EN
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q, in_ready_d;
`endif

    logic in_fire;
    logic out_fire;

    assign out_valid = out_valid_q;
    assign occupancy = occ_q;
    assign out_data  = main_q;
`ifdef SYN_PIPE_SKID_EN
    assign in_ready  = in_ready_q;
`else
    // Without a skid entry the stage can only accept while it empties.
    assign in_ready  = ~out_valid_q | out_ready;
`endif

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid_q & out_ready;

    // Next-state and datapath selection; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
`ifdef SYN_PIPE_SKID_EN
        skid_d  = skid_q;
`endif
        if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_DATA;
`ifdef SYN_PIPE_SKID_EN
            skid_d  = RESET_DATA;
`endif
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_data;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
`ifdef SYN_PIPE_SKID_EN
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
`endif
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
`ifdef SYN_PIPE_SKID_EN
                FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
`endif
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end

        // Status flags are precomputed so the outputs come straight from flops.
        out_valid_d = (state_d != EMPTY);
        occ_d       = state_d;
`ifdef SYN_PIPE_SKID_EN
        in_ready_d  = (state_d != FULL);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_DATA;
            out_valid_q <= 1'b0;
            occ_q       <= 2'd0;
`ifdef SYN_PIPE_SKID_EN
            skid_q      <= RESET_DATA;
            in_ready_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            out_valid_q <= out_valid_d;
            occ_q       <= occ_d;
`ifdef SYN_PIPE_SKID_EN
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
`endif
        end
    end

`ifndef SYNTHESIS
    // A stalled payload must not change underneath the consumer.
    a_hold_stable : assert property (@(posedge clk)
        (!rst && !flush && out_valid && !out_ready) |=> $stable(out_data));

    a_valid_occ : assert property (@(posedge clk)
        out_valid == (occupancy != 2'd0));

`ifdef SYN_PIPE_SKID_EN
    a_occ_range : assert property (@(posedge clk) occupancy <= 2'd2);
`else
    a_occ_range : assert property (@(posedge clk) occupancy <= 2'd1);
`endif
`endif

endmodule
